ups_drp_resp: RTL and testbench

- DRP responder and XADC stand-in. It accepts 12-bit samples from an external ADC front end and stores them in a per-channel register bank.
- Each stored sample raises busy/eoc/channel_out exactly as the XADC does.
- DRP read and write requests from a DRP initiator (den/daddr/dwe/di) are answered with drdy/do after a fixed latency.
- The existing pressure-sensor reader therefore works unchanged against either the XADC primitive or an external converter.

---
 rtl/ups_drp_resp.sv | 186 ++++++++++++++++++
 tb/tb_ups_drp_resp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ups_drp_resp.sv
// DRP responder standing in for the XADC: external ADC samples land in a
// per-channel register bank and are served to a DRP initiator with fixed latency.
module ups_drp_resp #(
    parameter int NUM_CH = 32,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] s_data,
    input  logic [4:0]  s_ch,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        busy,
    output logic        eoc,
    output logic [4:0]  channel_out,
    input  logic        den,
    input  logic [6:0]  daddr,
    input  logic        dwe,
    input  logic [15:0] di,
    output logic [15:0] do_out,
    output logic        drdy,
    output logic        drp_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_EOC
    } cap_state_t;

    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    cap_state_t  state_q;
    logic [11:0] cap_data_q;
    logic [4:0]  cap_ch_q;
    logic        s_ready_q;
    logic        busy_q;
    logic        eoc_q;
    logic [4:0]  chan_q;

    logic        pend_q;
    logic [2:0]  cnt_q;
    logic        rd_q;
    logic [15:0] snap_q;
    logic [15:0] do_q;
    logic        drdy_q;
    logic        err_q;

    logic [15:0] regs_q [NUM_CH];

    logic              drp_accept;
    logic [NUM_CH-1:0] cap_we_d;
    logic [NUM_CH-1:0] drp_we_d;
    logic [15:0]       rd_val_d;
    logic [15:0]       cap_word_d;

    assign drp_accept = den && !pend_q;
    assign cap_word_d = {cap_data_q, 4'b0000};

    // Capture FSM; outputs are registered so they reflect the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cap_data_q <= '0;
            cap_ch_q   <= '0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            eoc_q      <= 1'b0;
            chan_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_valid && s_ready_q) begin
                        cap_data_q <= s_data;
                        cap_ch_q   <= s_ch;
                        state_q    <= ST_WRITE;
                        s_ready_q  <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        s_ready_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_EOC;
                    busy_q  <= 1'b0;
                    eoc_q   <= 1'b1;
                    chan_q  <= cap_ch_q;
                end
                ST_EOC: begin
                    state_q   <= ST_IDLE;
                    eoc_q     <= 1'b0;
                    s_ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                    eoc_q     <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        cap_we_d = '0;
        drp_we_d = '0;
        rd_val_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cap_we_d[i] = (state_q == ST_WRITE) && (cap_ch_q == 5'(i));
            drp_we_d[i] = drp_accept && dwe && (daddr == 7'(i));
            if (daddr == 7'(i)) begin
                rd_val_d = regs_q[i];
            end
        end
    end

    // NOTE: the bank must read back zero after reset, so it is reset explicitly
    // and cannot map onto a RAM macro.
    // A DRP write overrides a same-cycle capture write to the same channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (drp_we_d[i]) begin
                    regs_q[i] <= di;
                end else if (cap_we_d[i]) begin
                    regs_q[i] <= cap_word_d;
                end
            end
        end
    end

    // DRP engine: read data is snapshotted at acceptance and released with drdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
            rd_q   <= 1'b0;
            snap_q <= '0;
            do_q   <= '0;
            drdy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            drdy_q <= 1'b0;
            if (den && pend_q) begin
                err_q <= 1'b1;
            end
            if (drp_accept) begin
                if (RD_LAT == 1) begin
                    drdy_q <= 1'b1;
                    if (!dwe) begin
                        do_q <= rd_val_d;
                    end
                end else begin
                    pend_q <= 1'b1;
                    cnt_q  <= LAT_M1;
                    rd_q   <= !dwe;
                    snap_q <= rd_val_d;
                end
            end else if (pend_q) begin
                if (cnt_q == 3'd1) begin
                    pend_q <= 1'b0;
                    drdy_q <= 1'b1;
                    if (rd_q) begin
                        do_q <= snap_q;
                    end
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
            end
        end
    end

    assign s_ready     = s_ready_q;
    assign busy        = busy_q;
    assign eoc         = eoc_q;
    assign channel_out = chan_q;
    assign do_out      = do_q;
    assign drdy        = drdy_q;
    assign drp_err     = err_q;

endmodule

// File: tb/tb_ups_drp_resp.sv
// Directed bench for ups_drp_resp: one instance at defaults (32 ch, latency 2)
// and one at 4 ch / latency 3, both driven by the same stimulus.
module tb_ups_drp_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] s_data = '0;
    logic [4:0]  s_ch = '0;
    logic        s_valid = 1'b0;
    logic        den = 1'b0;
    logic [6:0]  daddr = '0;
    logic        dwe = 1'b0;
    logic [15:0] di = '0;

    logic        s_ready_a, busy_a, eoc_a, drdy_a, err_a;
    logic [4:0]  chan_a;
    logic [15:0] do_a;
    logic        s_ready_b, busy_b, eoc_b, drdy_b, err_b;
    logic [4:0]  chan_b;
    logic [15:0] do_b;

    ups_drp_resp #(.NUM_CH(32), .RD_LAT(2)) u_a (
        .clk(clk), .rst(rst), .s_data(s_data), .s_ch(s_ch), .s_valid(s_valid),
        .s_ready(s_ready_a), .busy(busy_a), .eoc(eoc_a), .channel_out(chan_a),
        .den(den), .daddr(daddr), .dwe(dwe), .di(di),
        .do_out(do_a), .drdy(drdy_a), .drp_err(err_a)
    );

    ups_drp_resp #(.NUM_CH(4), .RD_LAT(3)) u_b (
        .clk(clk), .rst(rst), .s_data(s_data), .s_ch(s_ch), .s_valid(s_valid),
        .s_ready(s_ready_b), .busy(busy_b), .eoc(eoc_b), .channel_out(chan_b),
        .den(den), .daddr(daddr), .dwe(dwe), .di(di),
        .do_out(do_b), .drdy(drdy_b), .drp_err(err_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int          na, nb, lat_a, lat_b;
    logic [15:0] val_a, val_b;
    logic [11:0] m_rdy_a, m_rdy_b, m_err_a, m_err_b, m_eoc_a, m_eoc_b;
    logic [4:0]  ch_seen [3];
    int          n_eoc, n_ev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request, then observe cycles N+1..N+6 for acks.
    task automatic drp_txn(input logic [6:0] addr, input logic we, input logic [15:0] wd);
        den = 1'b1; daddr = addr; dwe = we; di = wd;
        tick();
        den = 1'b0; dwe = 1'b0;
        na = 0; nb = 0; lat_a = 0; lat_b = 0; val_a = '0; val_b = '0;
        for (int k = 1; k <= 6; k++) begin
            if (drdy_a) begin na++; lat_a = k; val_a = do_a; end
            if (drdy_b) begin nb++; lat_b = k; val_b = do_b; end
            tick();
        end
    endtask

    // Drive den per mask bit k in cycle k; record outputs seen in cycle k+1.
    task automatic drp_seq(input logic [11:0] den_mask);
        m_rdy_a = '0; m_rdy_b = '0; m_err_a = '0; m_err_b = '0;
        daddr = 7'h01; dwe = 1'b0;
        for (int k = 0; k < 11; k++) begin
            den = den_mask[k];
            tick();
            m_rdy_a[k+1] = drdy_a; m_rdy_b[k+1] = drdy_b;
            m_err_a[k+1] = err_a;  m_err_b[k+1] = err_b;
        end
        den = 1'b0;
    endtask

    // Present one sample in IDLE; returns in the WRITE cycle.
    task automatic cap_start(input logic [4:0] ch, input logic [11:0] data);
        s_valid = 1'b1; s_ch = ch; s_data = data;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_flags_a", {s_ready_a, busy_a, eoc_a, drdy_a, err_a}, 0);
        check("rst_flags_b", {s_ready_b, busy_b, eoc_b, drdy_b, err_b}, 0);
        check("rst_chan_do_a", {chan_a, do_a}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("ready_after_rst", {s_ready_a, s_ready_b}, 2'b11);

        // First sample on channel 17
        cap_start(5'd17, 12'hABC);
        check("write_cycle_a", {busy_a, eoc_a, s_ready_a}, 3'b100);
        tick();
        check("eoc_cycle_a", {busy_a, eoc_a, s_ready_a}, 3'b010);
        check("chan_a", chan_a, 17);
        check("eoc_b_oor_ch", {eoc_b, chan_b}, {1'b1, 5'd17});
        tick();
        check("idle_again_a", {busy_a, eoc_a, s_ready_a}, 3'b001);
        tick();

        // Back-to-back requests at RD_LAT spacing, no error yet
        drp_seq(12'h009);
        check("b2b_rdy_a", m_rdy_a, 12'h024);
        check("b2b_rdy_b", m_rdy_b, 12'h048);
        check("b2b_err", {m_err_a, m_err_b}, 0);

        drp_txn(7'h11, 1'b0, 16'h0);
        check("rd11_lat_a", lat_a, 2);
        check("rd11_val_a", val_a, 16'hABC0);
        check("rd11_lat_b", lat_b, 3);
        check("rd11_val_b", val_b, 16'h0000);
        check("rd11_cnt", {na[3:0], nb[3:0]}, 8'h11);

        // Writes ack without touching do_out
        drp_txn(7'h02, 1'b1, 16'h1234);
        check("wr02_lat", {lat_a[3:0], lat_b[3:0]}, 8'h23);
        check("wr02_cnt", {na[3:0], nb[3:0]}, 8'h11);
        check("wr02_do_kept_a", val_a, 16'hABC0);
        drp_txn(7'h02, 1'b0, 16'h0);
        check("rd02_a", val_a, 16'h1234);
        check("rd02_b", val_b, 16'h1234);
        drp_txn(7'h05, 1'b1, 16'hBEEF);
        check("wr05_oor_ack_b", nb, 1);
        drp_txn(7'h31, 1'b0, 16'h0);
        check("rd31_oor_a", val_a, 16'h0000);
        check("rd31_cnt_a", na, 1);
        drp_txn(7'h02, 1'b0, 16'h0);
        check("rd02_again_b", val_b, 16'h1234);
        drp_txn(7'h05, 1'b0, 16'h0);
        check("rd05_a", val_a, 16'hBEEF);
        check("rd05_oor_b", val_b, 16'h0000);
        check("rd05_cnt_b", nb, 1);

        // Capture WRITE colliding with a DRP read, then with a DRP write
        cap_start(5'd3, 12'h123);
        drp_txn(7'h03, 1'b0, 16'h0);
        check("coll_rd_pre_a", val_a, 16'h0000);
        drp_txn(7'h03, 1'b0, 16'h0);
        check("coll_rd_post_a", val_a, 16'h1230);
        check("coll_rd_post_b", val_b, 16'h1230);
        cap_start(5'd2, 12'hFFF);
        drp_txn(7'h02, 1'b1, 16'h0055);
        drp_txn(7'h02, 1'b0, 16'h0);
        check("coll_wr_a", val_a, 16'h0055);
        check("coll_wr_b", val_b, 16'h0055);

        // Throughput: s_valid held 9 cycles with a changing channel
        m_eoc_a = '0; m_eoc_b = '0; n_eoc = 0;
        for (int k = 0; k < 11; k++) begin
            s_valid = (k < 9); s_ch = 5'(8 + k); s_data = 12'(k + 1);
            tick();
            m_eoc_a[k+1] = eoc_a; m_eoc_b[k+1] = eoc_b;
            if (eoc_a) begin
                if (n_eoc < 3) ch_seen[n_eoc] = chan_a;
                n_eoc++;
            end
        end
        s_valid = 1'b0;
        check("tp_eoc_mask_a", m_eoc_a, 12'h124);
        check("tp_eoc_mask_b", m_eoc_b, 12'h124);
        check("tp_eoc_count", n_eoc, 3);
        check("tp_ch0", ch_seen[0], 8);
        check("tp_ch1", ch_seen[1], 11);
        check("tp_ch2", ch_seen[2], 14);
        drp_txn(7'h0B, 1'b0, 16'h0);
        check("tp_rd0b_a", val_a, 16'h0040);

        // Protocol error: den in the cycle after an accepted request
        drp_seq(12'h003);
        check("perr_rdy_a", m_rdy_a, 12'h004);
        check("perr_rdy_b", m_rdy_b, 12'h008);
        check("perr_err_a", m_err_a, 12'hFFC);
        check("perr_err_b", m_err_b, 12'hFFC);
        drp_txn(7'h11, 1'b0, 16'h0);
        check("perr_sticky", {err_a, err_b}, 2'b11);
        check("perr_clean_rd_a", val_a, 16'hABC0);

        // Reset one cycle after den
        den = 1'b1; daddr = 7'h02; dwe = 1'b0;
        tick();
        den = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_flags_a", {s_ready_a, busy_a, eoc_a, drdy_a, err_a}, 0);
        check("arst_chan_do_a", {chan_a, do_a}, 0);
        check("arst_flags_b", {s_ready_b, err_b, chan_b}, 0);
        tick(); tick();
        rst = 1'b0;
        n_ev = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (drdy_a || drdy_b) n_ev++;
        end
        check("arst_no_late_drdy", n_ev, 0);

        // Reset during capture WRITE
        cap_start(5'd4, 12'h777);
        check("arst2_busy_before", busy_a, 1);
        #2 rst = 1'b1;
        #1;
        check("arst2_flags", {busy_a, eoc_a, s_ready_a, busy_b, eoc_b}, 0);
        tick(); tick();
        rst = 1'b0;
        n_ev = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (eoc_a || eoc_b) n_ev++;
        end
        check("arst2_no_eoc", n_ev, 0);

        for (int i = 0; i < 32; i++) begin
            drp_txn(7'(i), 1'b0, 16'h0);
            check($sformatf("zero_a[%0d]", i), {na[3:0], val_a}, {4'h1, 16'h0000});
            if (i < 4) check($sformatf("zero_b[%0d]", i), {nb[3:0], val_b}, {4'h1, 16'h0000});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
